// File: rtl/avalon_st_packet_arbiter.sv
// Packet-aware round-robin arbiter: NUM_IN Avalon-ST sources share one sink.
// A grant is held for a whole packet. A new packet starts only when the
// downstream fill level leaves room. Overlong packets are cut short with a
// forced eop, and their remaining beats are drained.
module avalon_st_packet_arbiter #(
  parameter int NUM_IN          = 4,
  parameter int CH_WIDTH        = 2,
  parameter int DATA_WIDTH      = 42,
  parameter int FILL_WIDTH      = 5,
  parameter int START_THRESHOLD = 12,
  parameter int MAX_BEATS       = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_sop,
  input  logic [NUM_IN-1:0]            in_eop,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [CH_WIDTH-1:0]          out_channel,
  input  logic                         out_ready,
  input  logic [FILL_WIDTH-1:0]        sink_fill_level,
  output logic                         busy,
  output logic                         trunc_err
);

  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [GW-1:0]           grant, rr_last, pick, idx;
  logic [BW-1:0]           beat_cnt;
  logic [NUM_IN-1:0]       req;
  logic                    any_req, fill_ok, trunc_hit;
  logic                    g_valid, g_sop, g_eop;
  logic [DATA_WIDTH-1:0]   g_data;

  // Round-robin pick: scan downward so the nearest index after rr_last wins
  always_comb begin
    req     = in_valid & in_sop;
    any_req = 1'b0;
    pick    = '0;
    idx     = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = GW'((int'(rr_last) + k) % NUM_IN);
      if (req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  // Granted-source mux (constant indices keep the selects width-clean)
  always_comb begin
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == GW'(i)) begin
        g_valid = in_valid[i];
        g_sop   = in_sop[i];
        g_eop   = in_eop[i];
        g_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fill_ok   = int'(sink_fill_level) <= START_THRESHOLD;
  assign trunc_hit = (MAX_BEATS != 0) && (beat_cnt == LAST_BEAT) && !g_eop;

  // State register plus grant, round-robin pointer, beat counter and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_last   <= GW'(NUM_IN - 1);
      beat_cnt  <= '0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      trunc_err <= 1'b0;
      case (state)
        IDLE: if (state_nxt == XFER) begin
          grant    <= pick;
          rr_last  <= pick;
          beat_cnt <= '0;
        end
        XFER: if (g_valid && out_ready) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (trunc_hit) trunc_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state: fill gate only at packet start; leave on eop or truncation
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_req && fill_ok) state_nxt = XFER;
      XFER:  if (g_valid && out_ready) begin
        if (g_eop)          state_nxt = IDLE;
        else if (trunc_hit) state_nxt = DRAIN;
      end
      DRAIN: if (g_valid && g_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pass-through in XFER, swallow beats in DRAIN, all quiet in IDLE
  always_comb begin
    in_ready    = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_sop     = 1'b0;
    out_eop     = 1'b0;
    out_channel = CH_WIDTH'(grant);
    busy        = (state != IDLE);
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == GW'(i)) begin
        if (state == XFER)  in_ready[i] = out_ready;
        if (state == DRAIN) in_ready[i] = 1'b1;
      end
    end
    if (state == XFER) begin
      out_valid = g_valid;
      out_data  = g_data;
      out_sop   = g_sop;
      out_eop   = g_eop | trunc_hit;
    end
  end

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Scoreboard bench for avalon_st_packet_arbiter: per-source expected beat
// queues are filled when packets are queued for sending, and emptied as the
// sink accepts beats. A second instance with MAX_BEATS=4 covers truncation.
module tb_avalon_st_packet_arbiter;
  localparam int NI = 4;
  localparam int DW = 42;
  localparam int CW = 2;
  localparam int FW = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, out_ready;
  logic [NI-1:0]    in_valid, in_sop, in_eop;
  logic [NI*DW-1:0] in_data;
  logic [FW-1:0]    fill;

  logic [NI-1:0] a_in_ready, b_in_ready, s_in_ready;
  logic          a_out_valid, b_out_valid, s_out_valid;
  logic [DW-1:0] a_out_data, b_out_data, s_out_data;
  logic          a_out_sop, b_out_sop, s_out_sop;
  logic          a_out_eop, b_out_eop, s_out_eop;
  logic [CW-1:0] a_out_channel, b_out_channel, s_out_channel;
  logic          a_busy, b_busy, s_busy;
  logic          a_trunc_err, b_trunc_err, s_trunc_err;

  avalon_st_packet_arbiter #(.NUM_IN(NI), .CH_WIDTH(CW), .DATA_WIDTH(DW), .FILL_WIDTH(FW),
    .START_THRESHOLD(12), .MAX_BEATS(64)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_sop(a_out_sop), .out_eop(a_out_eop), .out_channel(a_out_channel),
    .out_ready(out_ready), .sink_fill_level(fill), .busy(a_busy), .trunc_err(a_trunc_err));

  avalon_st_packet_arbiter #(.NUM_IN(NI), .CH_WIDTH(CW), .DATA_WIDTH(DW), .FILL_WIDTH(FW),
    .START_THRESHOLD(12), .MAX_BEATS(4)) u_dut_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_sop(b_out_sop), .out_eop(b_out_eop), .out_channel(b_out_channel),
    .out_ready(out_ready), .sink_fill_level(fill), .busy(b_busy), .trunc_err(b_trunc_err));

  bit use_t, rdy_rand;

  always_comb begin
    if (use_t) begin
      s_in_ready = b_in_ready; s_out_valid = b_out_valid; s_out_data = b_out_data;
      s_out_sop = b_out_sop; s_out_eop = b_out_eop; s_out_channel = b_out_channel;
      s_busy = b_busy; s_trunc_err = b_trunc_err;
    end else begin
      s_in_ready = a_in_ready; s_out_valid = a_out_valid; s_out_data = a_out_data;
      s_out_sop = a_out_sop; s_out_eop = a_out_eop; s_out_channel = a_out_channel;
      s_busy = a_busy; s_trunc_err = a_trunc_err;
    end
  end

  beat_t src_q[NI][$];
  beat_t exp_q[NI][$];
  int    sop_log[$];

  int n_vec = 0, n_err = 0;
  int t_cyc, n_valid, n_busy, n_trunc, n_acc, first_valid, cur_ch, pkt_id;

  logic [NI-1:0] sm_in_ready;
  logic          sm_valid, sm_sop, sm_eop, sm_busy, sm_trunc;
  logic [DW-1:0] sm_data;
  logic [CW-1:0] sm_ch;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int log_at(int i);
    return (i < sop_log.size()) ? sop_log[i] : -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NI; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i]             = 1'b1;
        in_data[i*DW +: DW]     = src_q[i][0].data;
        in_sop[i]               = src_q[i][0].sop;
        in_eop[i]               = src_q[i][0].eop;
      end else begin
        in_valid[i]             = 1'b0;
        in_data[i*DW +: DW]     = '0;
        in_sop[i]               = 1'b0;
        in_eop[i]               = 1'b0;
      end
    end
  endtask

  // Queue a packet on a source; expected sink beats follow the length limit
  task automatic send_pkt(int src, int len);
    int mb;
    mb = use_t ? 4 : 64;
    for (int b = 0; b < len; b++) begin
      beat_t x, y;
      x.data = {4'(src), 22'(pkt_id), 16'(b)};
      x.sop  = (b == 0);
      x.eop  = (b == len - 1);
      src_q[src].push_back(x);
      if (mb == 0 || b < mb) begin
        y = x;
        if (mb != 0 && b == mb - 1) y.eop = 1'b1;
        exp_q[src].push_back(y);
      end
    end
    pkt_id++;
    drive();
  endtask

  // One cycle: sample mid-cycle, score accepted beats, then advance sources
  task automatic tick();
    logic [NI-1:0] hs;
    beat_t e;
    int ch;
    @(negedge clk);
    sm_in_ready = s_in_ready; sm_valid = s_out_valid; sm_data = s_out_data;
    sm_sop = s_out_sop; sm_eop = s_out_eop; sm_ch = s_out_channel;
    sm_busy = s_busy; sm_trunc = s_trunc_err;
    hs = in_valid & s_in_ready;
    if (sm_valid) begin
      n_valid++;
      if (first_valid < 0) first_valid = t_cyc;
    end
    if (sm_busy)  n_busy++;
    if (sm_trunc) n_trunc++;
    if (sm_valid && out_ready) begin
      n_acc++;
      ch = int'(sm_ch);
      if (sm_sop) begin
        sop_log.push_back(ch);
        cur_ch = ch;
      end else chk("ch_hold", 64'(ch), 64'(cur_ch));
      chk("exp_avail", 64'(exp_q[ch].size() > 0), 64'(1));
      if (exp_q[ch].size() > 0) begin
        e = exp_q[ch].pop_front();
        chk("beat_data", 64'(sm_data), 64'(e.data));
        chk("beat_sop", 64'(sm_sop), 64'(e.sop));
        chk("beat_eop", 64'(sm_eop), 64'(e.eop));
      end
    end
    t_cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic drain(string tag, int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      done = all_empty() && !sm_busy;
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  task automatic flush();
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    drive();
  endtask

  task automatic clr_stats();
    t_cyc = 0; n_valid = 0; n_busy = 0; n_trunc = 0; n_acc = 0; first_valid = -1;
    sop_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
    out_ready = 1'b1; fill = '0; use_t = 1'b0; rdy_rand = 1'b0;
    pkt_id = 0; cur_ch = 0;
    clr_stats();

    // Reset values
    tick();
    tick();
    chk("rst_in_ready", 64'(sm_in_ready), 64'(0));
    chk("rst_valid", 64'(sm_valid), 64'(0));
    chk("rst_sop", 64'(sm_sop), 64'(0));
    chk("rst_eop", 64'(sm_eop), 64'(0));
    chk("rst_busy", 64'(sm_busy), 64'(0));
    chk("rst_channel", 64'(sm_ch), 64'(0));
    chk("rst_data", 64'(sm_data), 64'(0));
    chk("rst_trunc", 64'(sm_trunc), 64'(0));
    reset = 1'b0;

    // 1: single 3-beat packet from source 0
    clr_stats();
    send_pkt(0, 3);
    drain("t1_done", 20);
    chk("t1_first_valid", 64'(first_valid), 64'(1));
    chk("t1_nvalid", 64'(n_valid), 64'(3));
    chk("t1_busy_cycles", 64'(n_busy), 64'(3));
    chk("t1_npkt", 64'(sop_log.size()), 64'(1));
    chk("t1_channel", 64'(log_at(0)), 64'(0));

    // 2: all sources stream single-beat packets -> strict rotation
    do_reset();
    clr_stats();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NI; s++) send_pkt(s, 1);
    drain("t2_done", 60);
    chk("t2_nvalid", 64'(n_valid), 64'(8));
    chk("t2_cycles", 64'(t_cyc), 64'(17));
    for (int i = 0; i < 8; i++) chk("t2_order", 64'(log_at(i)), 64'(i % NI));

    // 3: source 2 requests mid-packet of source 1 -> no interleave
    clr_stats();
    send_pkt(1, 5);
    tick();
    tick();
    send_pkt(2, 2);
    drain("t3_done", 40);
    chk("t3_npkt", 64'(sop_log.size()), 64'(2));
    chk("t3_first", 64'(log_at(0)), 64'(1));
    chk("t3_second", 64'(log_at(1)), 64'(2));
    chk("t3_nvalid", 64'(n_valid), 64'(7));

    // 4: fill-level gate at packet start only
    clr_stats();
    fill = FW'(13);
    send_pkt(0, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_ready", 64'(sm_in_ready), 64'(0));
      chk("t4_hold_busy", 64'(sm_busy), 64'(0));
    end
    fill = FW'(12);
    tick();
    chk("t4_gate_idle", 64'(sm_busy), 64'(0));
    fill = FW'(16);
    rdy_rand = 1'b1;
    tick();
    chk("t4_granted", 64'(sm_busy), 64'(1));
    chk("t4_channel", 64'(sm_ch), 64'(0));
    drain("t4_done", 200);
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    fill = '0;
    chk("t4_nacc", 64'(n_acc), 64'(4));

    // 5: MAX_BEATS=4 instance, 7-beat packet from source 3
    use_t = 1'b1;
    do_reset();
    clr_stats();
    send_pkt(3, 7);
    drain("t5_done", 60);
    chk("t5_nvalid", 64'(n_valid), 64'(4));
    chk("t5_trunc_pulses", 64'(n_trunc), 64'(1));
    chk("t5_busy_cycles", 64'(n_busy), 64'(7));
    use_t = 1'b0;
    do_reset();

    // 6: reset mid-packet with out_ready toggling
    clr_stats();
    rdy_rand = 1'b1;
    send_pkt(0, 5);
    for (int k = 0; k < 60 && n_acc < 1; k++) tick();
    chk("t6_started", 64'(n_acc >= 1), 64'(1));
    reset = 1'b1;
    tick();
    tick();
    chk("t6_rst_ready", 64'(sm_in_ready), 64'(0));
    chk("t6_rst_busy", 64'(sm_busy), 64'(0));
    chk("t6_rst_valid", 64'(sm_valid), 64'(0));
    reset = 1'b0;
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    flush();
    clr_stats();
    send_pkt(1, 1);
    send_pkt(0, 1);
    drain("t6_done", 20);
    chk("t6_first", 64'(log_at(0)), 64'(0));
    chk("t6_second", 64'(log_at(1)), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
